// File: rtl/branch_redirect.sv
// Control-flow decode/resolve between fetch and ID/EX: jump decode, a one-deep
// EX branch register, a mirror of the fetch PC, wrong-path squash and branch counters.
module branch_redirect #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      FetchData_IF,
  input  logic             AnyStall,
  input  logic [31:0]      RsData_ID,
  input  logic [31:0]      RtData_ID,
  output logic             Jump_ID,
  output logic [25:0]      JumpTgt_ID,
  output logic             BranchTaken_EX,
  output logic [31:0]      RedirectPc_EX,
  output logic             Squash_ID,
  output logic [31:0]      Pc_ID,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] TakenCnt
);

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  logic [31:0]      r_pc;
  logic             r_br_valid;
  logic             r_br_is_ne;
  logic             r_eq;
  logic [31:0]      r_redirect_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic [5:0]  w_op;
  logic [15:0] w_imm;
  logic        w_taken;
  logic        w_is_jump;
  logic        w_is_branch;
  logic [31:0] w_npc;
  logic [31:0] w_br_tgt;
  logic [31:0] w_next_pc;

  assign w_op        = FetchData_IF[31:26];
  assign w_imm       = FetchData_IF[15:0];
  assign w_taken     = r_br_valid & (r_br_is_ne ? ~r_eq : r_eq);
  assign w_is_jump   = ((w_op == OP_J) | (w_op == OP_JAL)) & ~w_taken;
  assign w_is_branch = ((w_op == OP_BEQ) | (w_op == OP_BNE)) & ~w_taken;
  assign w_npc       = r_pc + 32'd4;
  assign w_br_tgt    = w_npc + {{14{w_imm[15]}}, w_imm, 2'b00};

  // Same priority as fetch: EX redirect beats ID jump beats sequential.
  always_comb begin
    w_next_pc = w_npc;
    if (w_taken)
      w_next_pc = r_redirect_pc;
    else if (w_is_jump)
      w_next_pc = {w_npc[31:28], FetchData_IF[25:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= '0;
      r_br_valid    <= 1'b0;
      r_br_is_ne    <= 1'b0;
      r_eq          <= 1'b0;
      r_redirect_pc <= '0;
      r_branch_cnt  <= '0;
      r_taken_cnt   <= '0;
    end else if (!AnyStall) begin
      r_pc          <= w_next_pc;
      r_br_valid    <= w_is_branch;
      r_br_is_ne    <= (w_op == OP_BNE);
      r_eq          <= (RsData_ID == RtData_ID);
      r_redirect_pc <= w_br_tgt;
      if (r_br_valid && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_taken && (r_taken_cnt != '1))
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign Jump_ID        = w_is_jump;
  assign JumpTgt_ID     = FetchData_IF[25:0];
  assign BranchTaken_EX = w_taken;
  assign Squash_ID      = w_taken;
  assign RedirectPc_EX  = r_redirect_pc;
  assign Pc_ID          = r_pc;
  assign BranchCnt      = r_branch_cnt;
  assign TakenCnt       = r_taken_cnt;

endmodule

// File: tb/tb_branch_redirect.sv
// Scoreboard bench for branch_redirect: a behavioural model pushes expected
// per-cycle outputs, a negedge monitor pops and compares; directed checks on top.
module tb_branch_redirect;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [31:0]      FetchData_IF;
  logic             AnyStall;
  logic [31:0]      RsData_ID;
  logic [31:0]      RtData_ID;
  logic             Jump_ID;
  logic [25:0]      JumpTgt_ID;
  logic             BranchTaken_EX;
  logic [31:0]      RedirectPc_EX;
  logic             Squash_ID;
  logic [31:0]      Pc_ID;
  logic [CNT_W-1:0] BranchCnt;
  logic [CNT_W-1:0] TakenCnt;

  branch_redirect #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .FetchData_IF(FetchData_IF), .AnyStall(AnyStall),
    .RsData_ID(RsData_ID), .RtData_ID(RtData_ID), .Jump_ID(Jump_ID),
    .JumpTgt_ID(JumpTgt_ID), .BranchTaken_EX(BranchTaken_EX),
    .RedirectPc_EX(RedirectPc_EX), .Squash_ID(Squash_ID), .Pc_ID(Pc_ID),
    .BranchCnt(BranchCnt), .TakenCnt(TakenCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        jump;
    logic [25:0] tgt;
    logic        taken;
    logic [31:0] redirect;
    logic        squash;
    logic [31:0] pc;
    logic [31:0] bcnt;
    logic [31:0] tcnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state
  logic [31:0] m_pc, m_rpc, m_bc, m_tc;
  logic        m_bv, m_ne, m_eq;
  localparam logic [31:0] CNT_MAX = 32'((1 << CNT_W) - 1);

  // Monitor: compare against the oldest pushed expectation away from the edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("jump",     32'(Jump_ID),        32'(e.jump));
      chk("jtgt",     32'(JumpTgt_ID),     32'(e.tgt));
      chk("taken",    32'(BranchTaken_EX), 32'(e.taken));
      chk("redirect", RedirectPc_EX,       e.redirect);
      chk("squash",   32'(Squash_ID),      32'(e.squash));
      chk("pc",       Pc_ID,               e.pc);
      chk("bcnt",     32'(BranchCnt),      e.bcnt);
      chk("tcnt",     32'(TakenCnt),       e.tcnt);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    AnyStall = 1'b1;
    FetchData_IF = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    AnyStall = 1'b0;
    m_pc = '0; m_rpc = '0; m_bc = '0; m_tc = '0;
    m_bv = 1'b0; m_ne = 1'b0; m_eq = 1'b0;
  endtask

  // Drive one cycle at posedge+1, push expectation, advance model, wait for next edge.
  task automatic step(input logic [31:0] f, input logic st, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    logic [5:0]  op;
    logic        tk, jp;
    logic signed [15:0] imm;
    logic [31:0] npc;
    FetchData_IF = f; AnyStall = st; RsData_ID = rs; RtData_ID = rt;
    op  = f[31:26];
    imm = f[15:0];
    tk  = m_bv && (m_ne ? (m_eq == 1'b0) : m_eq);
    jp  = (op == 6'd2 || op == 6'd3) && !tk;
    e.jump = jp; e.tgt = f[25:0]; e.taken = tk; e.redirect = m_rpc;
    e.squash = tk; e.pc = m_pc; e.bcnt = m_bc; e.tcnt = m_tc;
    q.push_back(e);
    if (!st) begin
      npc = m_pc + 32'd4;
      if (m_bv && m_bc != CNT_MAX) m_bc = m_bc + 32'd1;
      if (tk && m_tc != CNT_MAX) m_tc = m_tc + 32'd1;
      m_rpc = npc + 32'(int'(imm) * 4);
      m_bv  = (op == 6'd4 || op == 6'd5) && !tk;
      m_ne  = (op == 6'd5);
      m_eq  = (rs == rt);
      if (tk)      m_pc = e.redirect;
      else if (jp) m_pc = {npc[31:28], f[25:0], 2'b00};
      else         m_pc = npc;
    end
    @(posedge clk); #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, 32'd0, 32'd0);
  endtask

  localparam logic [31:0] BEQ3   = 32'h1022_0003;
  localparam logic [31:0] BNEM2  = 32'h1422_FFFE;
  localparam logic [31:0] J40    = 32'h0800_0040;

  initial begin
    reset = 1'b1; AnyStall = 1'b0; FetchData_IF = '0; RsData_ID = '0; RtData_ID = '0;
    do_reset();

    // Sequential fetch from reset
    nops(3);
    chk("seq_pc", Pc_ID, 32'h0000_000C);
    nops(1);
    chk("pc_at_beq", Pc_ID, 32'h10);

    // Taken BEQ
    step(BEQ3, 1'b0, 32'd5, 32'd5);
    chk("beq_taken", 32'(BranchTaken_EX), 32'd1);
    chk("beq_tgt", RedirectPc_EX, 32'h20);
    chk("beq_squash", 32'(Squash_ID), 32'd1);
    nops(1);
    chk("beq_pc", Pc_ID, 32'h20);
    chk("beq_bcnt", 32'(BranchCnt), 32'd1);
    chk("beq_tcnt", 32'(TakenCnt), 32'd1);

    // BNE not taken, then taken
    do_reset(); nops(4);
    step(BNEM2, 1'b0, 32'd7, 32'd7);
    chk("bne_nt", 32'(BranchTaken_EX), 32'd0);
    nops(1);
    chk("bne_nt_pc", Pc_ID, 32'h18);
    chk("bne_nt_bcnt", 32'(BranchCnt), 32'd1);
    chk("bne_nt_tcnt", 32'(TakenCnt), 32'd0);
    do_reset(); nops(4);
    step(BNEM2, 1'b0, 32'd1, 32'd2);
    chk("bne_t", 32'(BranchTaken_EX), 32'd1);
    chk("bne_t_tgt", RedirectPc_EX, 32'h0C);
    nops(1);
    chk("bne_t_pc", Pc_ID, 32'h0C);

    // Jump
    do_reset(); nops(4);
    FetchData_IF = J40; #1;
    chk("j_jump", 32'(Jump_ID), 32'd1);
    chk("j_tgt", 32'(JumpTgt_ID), 32'h40);
    step(J40, 1'b0, 32'd0, 32'd0);
    chk("j_pc", Pc_ID, 32'h100);
    chk("j_squash", 32'(Squash_ID), 32'd0);

    // Taken BEQ in EX with J in ID: EX wins
    do_reset(); nops(4);
    step(BEQ3, 1'b0, 32'd5, 32'd5);
    FetchData_IF = J40; #1;
    chk("ex_wins_jump", 32'(Jump_ID), 32'd0);
    chk("ex_wins_sq", 32'(Squash_ID), 32'd1);
    step(J40, 1'b0, 32'd0, 32'd0);
    chk("ex_wins_pc", Pc_ID, 32'h20);

    // Stall with taken branch pending
    do_reset(); nops(4);
    step(BEQ3, 1'b0, 32'd5, 32'd5);
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 1'b1, 32'd0, 32'd0);
      chk("stall_pc", Pc_ID, 32'h14);
      chk("stall_taken", 32'(BranchTaken_EX), 32'd1);
      chk("stall_tcnt", 32'(TakenCnt), 32'd0);
    end
    nops(1);
    chk("rel_pc", Pc_ID, 32'h20);
    chk("rel_tcnt", 32'(TakenCnt), 32'd1);

    // Reset mid-branch discards the redirect
    do_reset(); nops(4);
    step(BEQ3, 1'b0, 32'd5, 32'd5);
    do_reset();
    chk("rst_taken", 32'(BranchTaken_EX), 32'd0);
    nops(1);

    // Saturation: many taken branches (BEQ, then squashed slot)
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(BEQ3, 1'b0, 32'd3, 32'd3);
      nops(1);
    end
    chk("sat_bcnt", 32'(BranchCnt), CNT_MAX);
    chk("sat_tcnt", 32'(TakenCnt), CNT_MAX);

    // Random mix
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [5:0]  op;
      logic [31:0] f;
      case ($urandom_range(5))
        0: op = 6'd2;
        1: op = 6'd3;
        2: op = 6'd4;
        3: op = 6'd5;
        4: op = 6'd8;
        default: op = 6'd0;
      endcase
      f = {op, 26'($urandom)};
      step(f, ($urandom_range(4) == 0), 32'($urandom_range(3)), 32'($urandom_range(3)));
    end

    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
